// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
//
// Burst reader that pulls a programmed number of words out of a synchronous
// FIFO (one-cycle read latency) and delivers them on a valid/ready stream
// through a 2-entry output buffer. Read strobes are throttled so that the
// buffer plus the word in flight can never exceed two entries. This allows
// one word per cycle when downstream is ready.
//
// Optional feature: define FIFO_READER_TIMEOUT_EN to compile in the
// empty-stall watchdog. When it fires, the burst is aborted after delivering
// the words already fetched. The watchdog limit is set by TIMEOUT_CYCLES.
// -----------------------------------------------------------------------------
module fifo_reader #(
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [LEN_WIDTH-1:0]  remaining,

    output logic                  fifo_cs,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,

    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    // Control state
    state_e                state_q,     state_d;
    logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  timeout_q,   timeout_d;

    // Datapath state: one word in flight from the FIFO plus a 2-entry buffer
    logic                  inflight_q,  inflight_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic                  wr_ptr_q,    wr_ptr_d;
    logic                  rd_ptr_q,    rd_ptr_d;
    logic [1:0]            buf_cnt_q,   buf_cnt_d;

    logic                  strobe;
    logic                  pop;
    logic [2:0]            projected;
    logic                  stall_limit;

    assign pop       = m_valid && m_ready;

    // Occupancy the buffer will have once the current in-flight word lands and
    // the current handshake (if any) retires. A strobe is only allowed while
    // this is below 2, so the word it fetches always has a free slot.
    assign projected = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(pop);

    // Read strobe: only in RUN, with data available, words left to issue and
    // room downstream. Held off while rst is asserted so nothing is popped
    // from the FIFO during a reset cycle.
    assign strobe = (state_q == ST_RUN) && !rst && !fifo_empty &&
                    (issue_cnt_q != '0) && (projected < 3'd2) && !stall_limit;

`ifdef FIFO_READER_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    assign stall_limit = (stall_cnt_q == STALL_W'(TIMEOUT_CYCLES));

    // Stall watchdog: counts RUN cycles that want to issue but cannot.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q != ST_RUN || strobe) begin
            stall_cnt_d = '0;
        end else if (issue_cnt_q != '0 && !stall_limit) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    // Stall watchdog register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    assign stall_limit = 1'b0;
`endif

    // Output buffer bookkeeping: land the in-flight word, retire handshakes.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        buf_d      = buf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = strobe;
        buf_cnt_d  = buf_cnt_q + 2'(inflight_q) - 2'(pop);
        if (inflight_q) begin
            buf_d[wr_ptr_q] = fifo_data_out;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    // FSM next-state and burst counters.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        remaining_d = remaining_q;
        timeout_d   = timeout_q;

        if (pop) begin
            remaining_d = remaining_q - LEN_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    issue_cnt_d = burst_len;
                    remaining_d = burst_len;
                    timeout_d   = 1'b0;
                    state_d     = (burst_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (strobe) begin
                    issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
                end
                if (stall_limit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FLUSH;
                end else if (issue_cnt_d == '0) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!inflight_q && buf_cnt_q == 2'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; an in-flight word is dropped.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= ST_IDLE;
            issue_cnt_q <= '0;
            remaining_q <= '0;
            timeout_q   <= 1'b0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            buf_cnt_q   <= 2'd0;
            // NOTE: the 2-entry buffer is reset on purpose because m_data must read 0 out of reset.
            buf_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            remaining_q <= remaining_d;
            timeout_q   <= timeout_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            buf_cnt_q   <= buf_cnt_d;
            buf_q       <= buf_d;
        end
    end

    // Outputs are pure decodes of registered state plus the strobe.
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign timeout    = timeout_q;
    assign remaining  = remaining_q;
    assign fifo_cs    = strobe;
    assign fifo_rd_en = strobe;
    assign m_valid    = (buf_cnt_q != 2'd0);
    assign m_data     = buf_q[rd_ptr_q];

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of FIFO read data and output stream data.
REQ-002 Parameter LEN_WIDTH, default 8, SHALL set the width of burst_len and remaining.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, SHALL set the empty-stall limit used when the timeout feature is compiled in.
REQ-004 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-005 Port clk, input, 1: rising-edge clock for all state.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port start, input, 1: one-cycle burst request, sampled only in IDLE.
REQ-008 Port burst_len, input, LEN_WIDTH: number of words to read, sampled with start.
REQ-009 Port busy, output, 1: high in any state other than IDLE.
REQ-010 Port done, output, 1: one-cycle pulse marking burst completion.
REQ-011 Port timeout, output, 1: sticky burst-abort flag, cleared on the next accepted start.
REQ-012 Port remaining, output, LEN_WIDTH: words of the current burst not yet delivered downstream.
REQ-013 Ports fifo_cs and fifo_rd_en, outputs, 1 each: FIFO chip select and read strobe, always driven identically.
REQ-014 Port fifo_data_out, input, DATA_WIDTH: FIFO read data, valid the cycle after the read strobe.
REQ-015 Port fifo_empty, input, 1: FIFO empty flag.
REQ-016 Ports m_valid (output, 1), m_data (output, DATA_WIDTH), m_ready (input, 1): downstream valid/ready stream.

Function
REQ-017 FSM states: IDLE, RUN, FLUSH, DONE; DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 IDLE + start: latch burst_len into issue counter and remaining, clear timeout; burst_len=0 goes to DONE, nonzero goes to RUN.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 RUN: read strobe = !fifo_empty AND issue counter>0 AND (buf_cnt + inflight - pop) < 2, where pop = m_valid AND m_ready and buf_cnt is the 2-entry output buffer occupancy.
REQ-021 Each strobe SHALL decrement the issue counter; the next-cycle fifo_data_out SHALL be written into the output buffer.
REQ-022 Sustained throughput SHALL be 1 word/cycle with FIFO non-empty and m_ready=1; first m_valid occurs 2 cycles after the first strobe.
REQ-023 Words SHALL leave in FIFO order; m_data SHALL hold stable while m_valid=1 and m_ready=0; the buffer SHALL never overflow.
REQ-024 remaining SHALL decrement on each downstream handshake.
REQ-025 Issue counter reaching 0 SHALL move RUN to FLUSH; FLUSH SHALL move to DONE when inflight=0 and buf_cnt=0.
REQ-026 No read strobe SHALL occur in IDLE, FLUSH or DONE.

Reset
REQ-027 rst SHALL force state IDLE, clear the buffer, in-flight flag and counters, and drive busy, done, timeout, remaining, fifo_cs, fifo_rd_en, m_valid and m_data to 0.
REQ-028 rst mid-burst SHALL abandon the burst with no done pulse; a word in flight SHALL be discarded.

Configuration
REQ-029 With FIFO_READER_TIMEOUT_EN defined, a stall counter SHALL count RUN cycles with issue counter>0 and no strobe, and SHALL clear on each strobe.
REQ-030 With FIFO_READER_TIMEOUT_EN defined, stall counter = TIMEOUT_CYCLES SHALL set timeout, stop issuing and enter FLUSH; buffered words are still delivered, then DONE pulses.
REQ-031 Without FIFO_READER_TIMEOUT_EN, the block SHALL wait indefinitely in RUN and timeout SHALL be tied to 0.

Verification
REQ-032 FIFO holds 8 words, burst_len=8, m_ready=1 -> 8 consecutive strobes, 8 words in order on back-to-back m_valid cycles, one done pulse, remaining reaches 0.
REQ-033 burst_len=4, m_ready toggles 1/0 -> at most 2 words buffered, m_data stable during stalls, exactly 4 strobes, done after the 4th handshake.
REQ-034 FIFO holds 2 words, burst_len=4, timeout on, TIMEOUT_CYCLES=64 -> 2 words delivered, timeout=1 after 64 empty cycles, done pulse, remaining=2.
REQ-035 burst_len=0 -> done 1 cycle after start, no strobe; start pulsed during RUN -> ignored.
REQ-036 rst asserted the cycle after a strobe in a burst_len=6 burst -> all outputs 0 next cycle, no done pulse; a new start reads normally.
